// File: rtl/mer_meas_ctrl_pkg.sv
// Shared constants and helpers for the MER measurement controller: default
// averaging length, LUT latency, the LUT error code and the power saturation limit.
package mer_meas_ctrl_pkg;

  localparam int MER_LOG2_N_DEF  = 10;
  localparam int MER_LUT_LAT_DEF = 3;
  localparam int MER_SQ_W        = 18;
  localparam int MER_W           = 7;

  localparam logic signed [MER_W-1:0] MER_ERR_CODE = -7'sd1;
  localparam logic [MER_SQ_W-1:0]     MER_PWR_SAT  = 18'd131071;

  // The LUT operand is signed, so the unsigned average is clipped to the largest positive value.
  function automatic logic signed [MER_SQ_W-1:0] sat_power(input logic [MER_SQ_W-1:0] avg);
    if (avg > MER_PWR_SAT) return $signed(MER_PWR_SAT);
    return $signed(avg);
  endfunction

endpackage

// File: rtl/mer_power_acc.sv
// One power path: accumulates 2^LOG2_N unsigned squared samples, then presents
// the saturated average as a held LUT operand.
module mer_power_acc
  import mer_meas_ctrl_pkg::*;
#(
  parameter int LOG2_N = MER_LOG2_N_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       add_en,
  input  logic                       load,
  input  logic [MER_SQ_W-1:0]        din,
  output logic signed [MER_SQ_W-1:0] power
);

  localparam int ACC_W = MER_SQ_W + LOG2_N;

  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [MER_SQ_W-1:0]        avg;
  logic signed [MER_SQ_W-1:0] power_q, power_d;

  // The load sees the sum including the final symbol of the block.
  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (add_en) acc_d = acc_q + ACC_W'(din);
    avg     = MER_SQ_W'(acc_d >> LOG2_N);
    power_d = power_q;
    if (load) power_d = sat_power(avg);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      power_q <= '0;
    end else begin
      acc_q   <= acc_d;
      power_q <= power_d;
    end
  end

  assign power = power_q;

endmodule

// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: averages mapper and error power over 2^LOG2_N
// symbols, drives the MER LUT, and captures its result with a valid pulse.
module mer_meas_ctrl
  import mer_meas_ctrl_pkg::*;
#(
  parameter int LOG2_N  = MER_LOG2_N_DEF,
  parameter int LUT_LAT = MER_LUT_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sym_en,
  input  logic [MER_SQ_W-1:0]        ref_sq,
  input  logic [MER_SQ_W-1:0]        err_sq,
  input  logic                       start,
  input  logic                       continuous,
  output logic signed [MER_SQ_W-1:0] lut_mapper_power,
  output logic signed [MER_SQ_W-1:0] lut_error_power,
  output logic                       lut_clk_en,
  output logic                       lut_reset,
  input  logic signed [MER_W-1:0]    lut_mer,
  output logic signed [MER_W-1:0]    mer_out,
  output logic                       mer_valid,
  output logic                       mer_fault,
  output logic                       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCUM   = 3'd1;
  localparam logic [2:0] S_PRESENT = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int WAIT_W = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;

  logic [2:0]               state_q, state_d;
  logic [LOG2_N-1:0]        cnt_q, cnt_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic signed [MER_W-1:0]  mer_q, mer_d;
  logic                     fault_q, fault_d;
  logic                     acc_clr, acc_add, acc_load;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    mer_d    = mer_q;
    fault_d  = fault_q;
    acc_clr  = 1'b0;
    acc_add  = 1'b0;
    acc_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || continuous) begin
          state_d = S_ACCUM;
          acc_clr = 1'b1;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        if (sym_en) begin
          acc_add = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            acc_load = 1'b1;
            state_d  = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      // The LUT output is valid in the last WAIT cycle; capture it so it lines up with mer_valid.
      S_WAIT: begin
        if (wait_q == WAIT_W'(LUT_LAT - 1)) begin
          state_d = S_DONE;
          mer_d   = lut_mer;
          fault_d = (lut_mer == MER_ERR_CODE);
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        if (continuous) begin
          state_d = S_ACCUM;
          acc_clr = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      mer_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      mer_q   <= mer_d;
      fault_q <= fault_d;
    end
  end

  mer_power_acc #(.LOG2_N(LOG2_N)) u_map_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .add_en  (acc_add),
    .load    (acc_load),
    .din     (ref_sq),
    .power   (lut_mapper_power)
  );

  mer_power_acc #(.LOG2_N(LOG2_N)) u_err_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .add_en  (acc_add),
    .load    (acc_load),
    .din     (err_sq),
    .power   (lut_error_power)
  );

  assign lut_clk_en = (state_q == S_PRESENT) || (state_q == S_WAIT);
  assign lut_reset  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mer_valid  = (state_q == S_DONE);
  assign mer_out    = mer_q;
  assign mer_fault  = fault_q;

endmodule
